// File: rtl/cpu7_csr_wrpipe_pkg.sv
// Shared widths and op encoding for the CSR write pipeline.
`ifndef LSOC1K_CSR_BIT
`define LSOC1K_CSR_BIT 14
`endif

package cpu7_csr_wrpipe_pkg;

  localparam int unsigned CSR_ADDR_W = `LSOC1K_CSR_BIT;
  localparam int unsigned CSR_DATA_W = 32;
  localparam int unsigned CSR_WCNT_W = 32;

  typedef enum logic {
    CSR_OP_WR   = 1'b0,
    CSR_OP_XCHG = 1'b1
  } csr_op_e;

endpackage

// File: rtl/cpu7_csr_wmerge.sv
// Masked merge of CSR write data: csrwr writes rd, csrxchg replaces only masked bits.
module cpu7_csr_wmerge #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              xchg,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mask,
  input  logic [DATA_W-1:0] old,
  output logic [DATA_W-1:0] wdata_mg_c
);

  always_comb begin
    wdata_mg_c = wdata;
    if (xchg) wdata_mg_c = (old & ~mask) | (wdata & mask);
  end

endmodule

// File: rtl/cpu7_csr_wrpipe.sv
// CSR write pipeline: carries csrwr/csrxchg from decode through e/m/w and commits at w.
// Optional write-commit counter output enabled by CPU7_CSR_WCNT_EN.
module cpu7_csr_wrpipe
  import cpu7_csr_wrpipe_pkg::*;
#(
  parameter int unsigned ADDR_W = CSR_ADDR_W,
  parameter int unsigned DATA_W = CSR_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              csr_wen_d,
  input  logic [ADDR_W-1:0] csr_waddr_d,
  input  logic              csr_xchg_d,
  input  logic              stall_e,
  input  logic              stall_m,
  input  logic              kill_m,
  input  logic [DATA_W-1:0] csr_wdata_e,
  input  logic [DATA_W-1:0] csr_mask_e,
  input  logic [DATA_W-1:0] csr_old_e,
  output logic              csr_wen_e,
  output logic [ADDR_W-1:0] csr_waddr_e,
  output logic [DATA_W-1:0] csr_wdata_e_mg,
  output logic              csr_wen_m,
  output logic [ADDR_W-1:0] csr_waddr_m,
  output logic [DATA_W-1:0] csr_wdata_m,
  output logic              csr_wen_w,
  output logic [ADDR_W-1:0] csr_waddr_w,
  output logic [DATA_W-1:0] csr_wdata_w
`ifdef CPU7_CSR_WCNT_EN
  ,
  output logic [CSR_WCNT_W-1:0] csr_wcnt
`endif
);

  logic              e_v;
  logic [ADDR_W-1:0] e_addr;
  csr_op_e           e_op;
  logic              m_v;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic              w_v;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              hold_e;
  logic              hold_m;
  logic [DATA_W-1:0] wdata_mg;

  assign hold_m = stall_m;
  assign hold_e = stall_e | stall_m;

  cpu7_csr_wmerge #(.DATA_W(DATA_W)) u_wmerge (
    .xchg       (e_op == CSR_OP_XCHG),
    .wdata      (csr_wdata_e),
    .mask       (csr_mask_e),
    .old        (csr_old_e),
    .wdata_mg_c (wdata_mg)
  );

  // Stage registers; addr/data always load so invalid stages stay deterministic.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_v    <= 1'b0;
      e_addr <= '0;
      e_op   <= CSR_OP_WR;
      m_v    <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      w_v    <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else begin
      if (!hold_e) begin
        e_addr <= csr_waddr_d;
        e_op   <= csr_op_e'(csr_xchg_d);
      end
      if (kill_m)       e_v <= 1'b0;
      else if (!hold_e) e_v <= csr_wen_d;

      if (!hold_m) begin
        m_addr <= e_addr;
        m_data <= wdata_mg;
      end
      if (kill_m)       m_v <= 1'b0;
      else if (!hold_m) m_v <= e_v & ~hold_e;

      // A held m must not commit twice, and a killed m never commits.
      w_addr <= m_addr;
      w_data <= m_data;
      w_v    <= m_v & ~hold_m & ~kill_m;
    end
  end

  assign csr_wen_e      = e_v;
  assign csr_waddr_e    = e_addr;
  assign csr_wdata_e_mg = wdata_mg;
  assign csr_wen_m      = m_v;
  assign csr_waddr_m    = m_addr;
  assign csr_wdata_m    = m_data;
  assign csr_wen_w      = w_v;
  assign csr_waddr_w    = w_addr;
  assign csr_wdata_w    = w_data;

`ifdef CPU7_CSR_WCNT_EN
  // Committed-write counter, wraps naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  csr_wcnt <= '0;
    else if (w_v) csr_wcnt <= csr_wcnt + CSR_WCNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_cpu7_csr_wrpipe.sv
// Scoreboard bench for cpu7_csr_wrpipe: stimulus pushes expected commits, a monitor checks them.
module tb_cpu7_csr_wrpipe;
  import cpu7_csr_wrpipe_pkg::*;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  csr_wen_d;
  logic [CSR_ADDR_W-1:0] csr_waddr_d;
  logic                  csr_xchg_d;
  logic                  stall_e;
  logic                  stall_m;
  logic                  kill_m;
  logic [31:0]           csr_wdata_e;
  logic [31:0]           csr_mask_e;
  logic [31:0]           csr_old_e;
  logic                  csr_wen_e;
  logic [CSR_ADDR_W-1:0] csr_waddr_e;
  logic [31:0]           csr_wdata_e_mg;
  logic                  csr_wen_m;
  logic [CSR_ADDR_W-1:0] csr_waddr_m;
  logic [31:0]           csr_wdata_m;
  logic                  csr_wen_w;
  logic [CSR_ADDR_W-1:0] csr_waddr_w;
  logic [31:0]           csr_wdata_w;
`ifdef CPU7_CSR_WCNT_EN
  logic [31:0]           csr_wcnt;
`endif

  cpu7_csr_wrpipe dut (
    .clk            (clk),
    .resetn         (resetn),
    .csr_wen_d      (csr_wen_d),
    .csr_waddr_d    (csr_waddr_d),
    .csr_xchg_d     (csr_xchg_d),
    .stall_e        (stall_e),
    .stall_m        (stall_m),
    .kill_m         (kill_m),
    .csr_wdata_e    (csr_wdata_e),
    .csr_mask_e     (csr_mask_e),
    .csr_old_e      (csr_old_e),
    .csr_wen_e      (csr_wen_e),
    .csr_waddr_e    (csr_waddr_e),
    .csr_wdata_e_mg (csr_wdata_e_mg),
    .csr_wen_m      (csr_wen_m),
    .csr_waddr_m    (csr_waddr_m),
    .csr_wdata_m    (csr_wdata_m),
    .csr_wen_w      (csr_wen_w),
    .csr_waddr_w    (csr_waddr_w),
    .csr_wdata_w    (csr_wdata_w)
`ifdef CPU7_CSR_WCNT_EN
    ,
    .csr_wcnt       (csr_wcnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CSR_ADDR_W-1:0] a;
    logic [31:0]           d;
    int                    c;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_commit = 0;
  logic [31:0] p_wd, p_mk, p_od;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every commit pulse must match the oldest expected commit, including its cycle.
  always @(negedge clk) begin
    if (csr_wen_w === 1'b1) begin
      n_commit++;
      if (q.size() == 0) begin
        chk("unexpected_commit", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("commit_addr", 32'(csr_waddr_w), 32'(e.a));
        chk("commit_data", csr_wdata_w, e.d);
        chk("commit_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  // lat = 0 means the write is expected never to commit.
  task automatic issue(input logic [CSR_ADDR_W-1:0] a, input logic x, input logic [31:0] wd,
                       input logic [31:0] mk, input logic [31:0] od, input logic [31:0] ex,
                       input int lat);
    csr_wen_d   = 1'b1;
    csr_waddr_d = a;
    csr_xchg_d  = x;
    p_wd = wd; p_mk = mk; p_od = od;
    if (lat > 0) begin
      exp_t e;
      e.a = a; e.d = ex; e.c = cyc + lat;
      q.push_back(e);
    end
  endtask

  // Advance one cycle; e-stage operands follow an instruction that entered e.
  task automatic tick();
    logic took;
    took = csr_wen_d && !stall_e && !stall_m;
    @(posedge clk);
    #1;
    if (took) begin
      csr_wdata_e = p_wd; csr_mask_e = p_mk; csr_old_e = p_od;
    end
    csr_wen_d = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; csr_wen_d = 1'b0; csr_waddr_d = '0; csr_xchg_d = 1'b0;
    stall_e = 1'b0; stall_m = 1'b0; kill_m = 1'b0;
    csr_wdata_e = '0; csr_mask_e = '0; csr_old_e = '0;
    p_wd = '0; p_mk = '0; p_od = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen_e", 32'(csr_wen_e), 32'd0);
    chk("rst_wen_m", 32'(csr_wen_m), 32'd0);
    chk("rst_wen_w", 32'(csr_wen_w), 32'd0);
    chk("rst_wdata_w", csr_wdata_w, 32'd0);
    chk("rst_waddr_w", 32'(csr_waddr_w), 32'd0);
    resetn = 1'b1;
    tick();
    chk("post_rst_wen_w", 32'(csr_wen_w), 32'd0);

    // csrwr, no stalls
    issue(CSR_ADDR_W'(12'h006), 1'b0, 32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF, 3);
    tick();
    chk("wr_wen_e", 32'(csr_wen_e), 32'd1);
    chk("wr_waddr_e", 32'(csr_waddr_e), 32'h006);
    chk("wr_mg", csr_wdata_e_mg, 32'hDEADBEEF);
    tick();
    chk("wr_wen_m", 32'(csr_wen_m), 32'd1);
    chk("wr_wdata_m", csr_wdata_m, 32'hDEADBEEF);
    tick(); tick();

    // csrxchg merges
    issue(CSR_ADDR_W'(12'h005), 1'b1, 32'h12345678, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFF5678, 3);
    tick();
    chk("xchg_mg", csr_wdata_e_mg, 32'hFFFF5678);
    tick();
    chk("xchg_wdata_m", csr_wdata_m, 32'hFFFF5678);
    tick(); tick();
    issue(CSR_ADDR_W'(12'h041), 1'b1, 32'h12345678, 32'hF0F0F0F0, 32'hAAAA5555, 32'h1A3A5575, 3);
    tick();
    chk("xchg2_mg", csr_wdata_e_mg, 32'h1A3A5575);
    tick(); tick(); tick();
    issue(CSR_ADDR_W'(12'h042), 1'b0, 32'h0BADF00D, 32'hFFFFFFFF, 32'h11111111, 32'h0BADF00D, 3);
    tick();
    chk("wr_ignores_mask", csr_wdata_e_mg, 32'h0BADF00D);
    tick(); tick(); tick();

    // stall_e for 2 cycles with the write in e: commit slips to +5
    issue(CSR_ADDR_W'(12'h010), 1'b0, 32'hCAFE0001, 32'h0, 32'h0, 32'hCAFE0001, 5);
    tick();
    stall_e = 1'b1;
    tick();
    chk("stall_e_hold_v", 32'(csr_wen_e), 32'd1);
    chk("stall_e_hold_addr", 32'(csr_waddr_e), 32'h010);
    chk("stall_e_bubble1", 32'(csr_wen_m), 32'd0);
    tick();
    chk("stall_e_bubble2", 32'(csr_wen_m), 32'd0);
    stall_e = 1'b0;
    tick();
    chk("stall_e_m_valid", 32'(csr_wen_m), 32'd1);
    tick(); tick();

    // stall_m for 1 cycle with the write in m: commit at +4, single pulse
    issue(CSR_ADDR_W'(12'h020), 1'b0, 32'hCAFE0002, 32'h0, 32'h0, 32'hCAFE0002, 4);
    tick(); tick();
    stall_m = 1'b1;
    tick();
    chk("stall_m_hold", 32'(csr_wen_m), 32'd1);
    chk("stall_m_no_commit", 32'(csr_wen_w), 32'd0);
    stall_m = 1'b0;
    tick();
    chk("stall_m_commit", 32'(csr_wen_w), 32'd1);
    tick();
    chk("stall_m_single_pulse", 32'(csr_wen_w), 32'd0);
    tick();

    // back-to-back writes to one address commit in order
    issue(CSR_ADDR_W'(12'h030), 1'b0, 32'h00000001, 32'h0, 32'h0, 32'h00000001, 3);
    tick();
    issue(CSR_ADDR_W'(12'h030), 1'b1, 32'h00000020, 32'h000000F0, 32'h00000001, 32'h00000021, 3);
    tick();
    issue(CSR_ADDR_W'(12'h030), 1'b0, 32'h00000003, 32'h0, 32'h00000021, 32'h00000003, 3);
    tick(); tick(); tick(); tick();

    // kill_m with writes in e and m: both dropped
    issue(CSR_ADDR_W'(12'h040), 1'b0, 32'h0000AAAA, 32'h0, 32'h0, 32'h0, 0);
    tick();
    issue(CSR_ADDR_W'(12'h041), 1'b0, 32'h0000BBBB, 32'h0, 32'h0, 32'h0, 0);
    tick();
    kill_m = 1'b1;
    tick();
    kill_m = 1'b0;
    chk("kill_wen_e", 32'(csr_wen_e), 32'd0);
    chk("kill_wen_m", 32'(csr_wen_m), 32'd0);
    chk("kill_wen_w", 32'(csr_wen_w), 32'd0);
    tick();
    chk("kill_wen_w_next", 32'(csr_wen_w), 32'd0);
    tick();

    // reset mid-stream drops the in-flight write
    issue(CSR_ADDR_W'(12'h050), 1'b0, 32'h55AA55AA, 32'h0, 32'h0, 32'h0, 0);
    tick(); tick();
    resetn = 1'b0;
    #1;
    chk("midrst_wen_e", 32'(csr_wen_e), 32'd0);
    chk("midrst_wen_m", 32'(csr_wen_m), 32'd0);
    chk("midrst_wdata_m", csr_wdata_m, 32'd0);
    chk("midrst_wen_w", 32'(csr_wen_w), 32'd0);
    n_commit = 0;
    tick(); tick();
    resetn = 1'b1;
    repeat (4) tick();

    // three commits after reset
    issue(CSR_ADDR_W'(12'h060), 1'b0, 32'h00000100, 32'h0, 32'h0, 32'h00000100, 3);
    tick();
    issue(CSR_ADDR_W'(12'h061), 1'b0, 32'h00000200, 32'h0, 32'h0, 32'h00000200, 3);
    tick();
    issue(CSR_ADDR_W'(12'h062), 1'b0, 32'h00000300, 32'h0, 32'h0, 32'h00000300, 3);
    tick();

    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
`ifdef CPU7_CSR_WCNT_EN
    chk("wcnt_after_reset", csr_wcnt, 32'd3);
    chk("wcnt_model", csr_wcnt, 32'(n_commit));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
